dram_arbiter: RTL
=================

# dram_arbiter

Two-master arbiter for the single-port data RAM (1024 x 32, synchronous read, one-cycle latency). It shares the RAM between master 0, the core data port behind the memory controller, and master 1, a loader/debug port that fills or inspects data memory while the core runs. It sequences each access as a grant, an optional read-return cycle and a release, using a fixed-priority policy with a starvation guard for master 1. It sits between the memory controller and the RAM, in the divided-clock domain.

## Interface

- AW, 10, RAM word-address width
- DW, 32, data width
- STARVE_LIMIT, 4, maximum consecutive master-0 grants while master 1 is pending (range 1..15)

- CLK  in  1  clock (divided system clock)
- RST  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request, masters 0/1
- we0, we1  in  1  1 = write, 0 = read; valid while req is high
- addr0, addr1  in  AW  word address
- wdata0, wdata1  in  DW  write data
- gnt0, gnt1  out  1  one-cycle pulse: the request was accepted
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata holds read data for that master
- rdata  out  DW  read data, shared; qualified by rvalid0/rvalid1
- ram_addr  out  AW  to RAM address
- ram_wdata  out  DW  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DW  RAM read data, valid one cycle after the address is sampled
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner and register its we, addr and wdata into the owner, ram_addr, ram_wdata and write-flag registers. Move to ACCESS.
- ACCESS (one cycle):
  - gnt(owner) = 1.
  - ram_wren = write-flag.
  - Next state is IDLE for a write, RDATA for a read.
- RDATA (one cycle):
  - rvalid(owner) = 1 and rdata = ram_q.
  - Next state is IDLE.
- Arbitration, evaluated in IDLE only:
  - If only one req is high, that master wins.
  - If both are high, master 0 wins unless starve_cnt == STARVE_LIMIT, in which case master 1 wins.
- starve_cnt, 4 bits:
  - Increments on every master-0 win while req1 is high.
  - Clears on a master-1 win, and in any IDLE cycle where req1 is low.
  - Saturates at STARVE_LIMIT.
- Request rules:
  - A master holds req, we, addr and wdata stable until its gnt pulse.
  - A master may drop req, or present a new request, in the cycle after gnt.
  - If req drops before it is granted, the request is silently discarded; no gnt is issued.
- Request fields are captured only on the IDLE→ACCESS edge. Changes to them after that edge do not affect the access in flight.
- ram_addr and ram_wdata hold their last values outside ACCESS. ram_wren is 0 in every state except ACCESS-with-write.
- rdata holds its last value when neither rvalid is high.

## Timing

- Reset values: state = IDLE; gnt0/1, rvalid0/1, ram_wren and busy = 0; ram_addr, ram_wdata, rdata and starve_cnt = 0; owner = 0.
- All outputs are registered or decoded from state registers only. There are no combinational paths from req*/addr*/we*/wdata* to any output.
- Write, req sampled in cycle T (IDLE):
  - T+1: gnt and ram_wren.
  - T+2: IDLE, ready to accept a new request.
- Read, req sampled in cycle T:
  - T+1: gnt, RAM samples address.
  - T+2: rvalid and rdata.
  - T+3: IDLE.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- Simultaneous req0/req1 in IDLE: resolved by the arbitration rule above. The loser keeps its request pending and is re-evaluated in the next IDLE cycle.
- RST asserted mid-ACCESS or mid-RDATA: all outputs clear immediately and the transaction is aborted. No gnt/rvalid appears after RST is released. A write aborted in ACCESS may or may not have reached RAM.

## Test plan

- Reset: RST=1 with random inputs → all outputs 0 and busy=0. RST released with no req → IDLE and all outputs still 0.
- Single write: master 0 writes 0xDEADBEEF to addr 0x012 → gnt0 and ram_wren=1 with ram_addr=0x012 in the cycle after sampling. A following master-0 read of 0x012 → rvalid0 with rdata=0xDEADBEEF exactly 2 cycles after sampling.
- Contention: req0 and req1 both held with reads to 0x001 and 0x002, STARVE_LIMIT=4 → grant sequence 0,0,0,0,1,0,0,0,0,1. Each rvalid targets the correct master and returns the correct data.
- Only master 1: req1 alone, 8 back-to-back writes to 0x3F8..0x3FF → gnt1 every 2 cycles. RAM contents match. starve_cnt stays 0.
- Request withdrawal: req1 raised then dropped while master 0 is being served → no gnt1 and no RAM access to addr1.
- Reset mid-read: RST asserted in the RDATA cycle → rvalid drops immediately. No rvalid after release. The next read completes normally.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares a single-port 1024x32 synchronous data RAM between
// master 0 (core data port) and master 1 (loader/debug port).
// Fixed priority to master 0. A starvation counter forces a master-1 win
// after STARVE_LIMIT consecutive master-0 wins while master 1 is waiting.
// Each access is IDLE -> ACCESS (-> RDATA for reads) -> IDLE.
`timescale 1ns/1ps
module dram_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDATA  = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t          r_state;
   state_t          w_state_next;
   logic [3:0]      r_starve;
   logic [3:0]      w_starve_next;
   logic            w_take;
   logic            w_win1;
   logic            w_sel_we;
   logic [AW-1:0]   w_sel_addr;
   logic [DW-1:0]   w_sel_wdata;

   logic            r_owner;
   logic            r_we;
   logic [AW-1:0]   r_ram_addr;
   logic [DW-1:0]   r_ram_wdata;
   logic            r_gnt0;
   logic            r_gnt1;
   logic            r_rvalid0;
   logic            r_rvalid1;
   logic            r_wren;
   logic            r_busy;
   logic [DW-1:0]   r_rdata_hold;

   // Request fields of the winning master.
   assign w_sel_we    = w_win1 ? we1    : we0;
   assign w_sel_addr  = w_win1 ? addr1  : addr0;
   assign w_sel_wdata = w_win1 ? wdata1 : wdata0;

   // Next state, arbitration and starvation counter update (IDLE only arbitrates).
   always_comb begin
      w_state_next  = r_state;
      w_take        = 1'b0;
      w_win1        = 1'b0;
      w_starve_next = r_starve;
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_take       = 1'b1;
               w_state_next = ACCESS;
               if (req1 && (!req0 || (r_starve == LIMIT))) begin
                  w_win1 = 1'b1;
               end else begin
                  w_win1 = 1'b0;
               end
            end else begin
               w_state_next = IDLE;
            end
            if (!req1) begin
               w_starve_next = 4'd0;
            end else if (w_win1) begin
               w_starve_next = 4'd0;
            end else if (r_starve < LIMIT) begin
               w_starve_next = r_starve + 4'd1;
            end else begin
               w_starve_next = r_starve;
            end
         end
         ACCESS: begin
            if (r_we) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = RDATA;
            end
         end
         RDATA: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State register and starvation counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= IDLE;
         r_starve <= 4'd0;
      end else begin
         r_state  <= w_state_next;
         r_starve <= w_starve_next;
      end
   end

   // Capture the winner's request on the IDLE->ACCESS edge; hold otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_ram_addr  <= {AW{1'b0}};
         r_ram_wdata <= {DW{1'b0}};
      end else if (w_take) begin
         r_owner     <= w_win1;
         r_we        <= w_sel_we;
         r_ram_addr  <= w_sel_addr;
         r_ram_wdata <= w_sel_wdata;
      end
   end

   // Registered handshake pulses, RAM write enable and busy flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_wren    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_gnt0    <= w_take && !w_win1;
         r_gnt1    <= w_take && w_win1;
         r_wren    <= w_take && w_sel_we;
         r_rvalid0 <= (r_state == ACCESS) && !r_we && !r_owner;
         r_rvalid1 <= (r_state == ACCESS) && !r_we && r_owner;
         r_busy    <= (w_state_next != IDLE);
      end
   end

   // Keep the last returned word so rdata holds between read returns.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdata_hold <= {DW{1'b0}};
      end else if (r_rvalid0 || r_rvalid1) begin
         r_rdata_hold <= ram_q;
      end
   end

   // RAM data arrives in the RDATA cycle itself, so it bypasses the hold register.
   assign rdata     = (r_rvalid0 || r_rvalid1) ? ram_q : r_rdata_hold;
   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign rvalid0   = r_rvalid0;
   assign rvalid1   = r_rvalid1;
   assign ram_wren  = r_wren;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign busy      = r_busy;

endmodule
